// File: rtl/block_pe_pkg.sv
// Shared definitions for the CGRA processing element: opcodes, select-code
// helpers and configuration field offsets.
package block_pe_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_PASS = 4'd9,
    OP_ACC  = 4'd10
  } opcode_e;

  function automatic int sel_w(input int n_in);
    return $clog2(n_in + 2);
  endfunction

  function automatic int osel_w(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  // Operand select codes beyond the input ports.
  function automatic int sel_fb(input int n_in);
    return n_in;
  endfunction

  function automatic int sel_const(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int off_sel_b(input int n_in);
    return sel_w(n_in);
  endfunction

  function automatic int off_opcode(input int n_in);
    return 2 * sel_w(n_in);
  endfunction

  function automatic int off_const(input int n_in);
    return off_opcode(n_in) + OPCODE_W;
  endfunction

  function automatic int off_acc_len(input int width, input int n_in);
    return off_const(n_in) + width;
  endfunction

  function automatic int off_out_sel(input int width, input int n_in, input int cnt_w);
    return off_acc_len(width, n_in) + cnt_w;
  endfunction

  function automatic int cfg_w(input int width, input int n_in, input int n_out, input int cnt_w);
    return off_out_sel(width, n_in, cnt_w) + n_out * osel_w(n_in);
  endfunction

endpackage

// File: rtl/pe_cfg_chain.sv
// Serial configuration shift register; bits enter at the MSB and leave at
// cfg[0], so PEs can be daisy-chained into a fabric column.
module pe_cfg_chain #(
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_config_en,
  input  logic             i_config_in,
  output logic [CFG_W-1:0] o_cfg,
  output logic             o_config_out
);

  logic [CFG_W-1:0] r_cfg;

  // NOTE: clocked state is assigned with <= only; a blocking write here would
  // let later readers in the same time step see the post-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg <= '0;
    end else if (i_config_en) begin
      r_cfg <= {i_config_in, r_cfg[CFG_W-1:1]};
    end
  end

  assign o_cfg        = r_cfg;
  assign o_config_out = r_cfg[0];

endmodule

// File: rtl/block_pe_param.sv
// Parametrised CGRA processing element: operand crossbar with per-operand
// latches, one ALU with accumulate mode, and selectable registered outputs.
module block_pe_param
  import block_pe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   config_en,
  input  logic                   config_in,
  output logic                   config_out,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  output logic                   err_overrun
);

  localparam int SEL_W     = sel_w(N_IN);
  localparam int OSEL_W    = osel_w(N_IN);
  localparam int CFG_W     = cfg_w(WIDTH, N_IN, N_OUT, CNT_W);
  localparam int SH_W      = $clog2(WIDTH);
  localparam int OFF_SEL_B = off_sel_b(N_IN);
  localparam int OFF_OP    = off_opcode(N_IN);
  localparam int OFF_CONST = off_const(N_IN);
  localparam int OFF_ACC   = off_acc_len(WIDTH, N_IN);
  localparam int OFF_OSEL  = off_out_sel(WIDTH, N_IN, CNT_W);

  logic [CFG_W-1:0]    w_cfg;
  logic [SEL_W-1:0]    w_sel_a, w_sel_b;
  logic [OPCODE_W-1:0] w_op;
  logic [WIDTH-1:0]    w_const;
  logic [CNT_W-1:0]    w_acc_len, w_len_m1;

  pe_cfg_chain #(.CFG_W(CFG_W)) u_cfg (
    .clk         (clk),
    .reset       (reset),
    .i_config_en (config_en),
    .i_config_in (config_in),
    .o_cfg       (w_cfg),
    .o_config_out(config_out)
  );

  assign w_sel_a   = w_cfg[0 +: SEL_W];
  assign w_sel_b   = w_cfg[OFF_SEL_B +: SEL_W];
  assign w_op      = w_cfg[OFF_OP +: OPCODE_W];
  assign w_const   = w_cfg[OFF_CONST +: WIDTH];
  assign w_acc_len = w_cfg[OFF_ACC +: CNT_W];
  assign w_len_m1  = (w_acc_len == '0) ? '0 : w_acc_len - CNT_W'(1);

  logic             r_val_a, r_val_b, r_err;
  logic [WIDTH-1:0] r_lat_a, r_lat_b, r_result, r_acc;
  logic [CNT_W-1:0] r_cnt;

  // Returns {is_input_port, valid, data} for one operand select code.
  function automatic logic [WIDTH+1:0] f_pick(
    input logic [SEL_W-1:0]      sel,
    input logic [N_IN*WIDTH-1:0] data,
    input logic [N_IN-1:0]       valid,
    input logic [WIDTH-1:0]      fb,
    input logic [WIDTH-1:0]      cst
  );
    logic [WIDTH+1:0] v;
    v = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) v = {1'b1, valid[k], data[k*WIDTH +: WIDTH]};
    end
    if (sel == SEL_W'(sel_fb(N_IN)))         v = {2'b01, fb};
    else if (sel == SEL_W'(sel_const(N_IN))) v = {2'b01, cst};
    return v;
  endfunction

  logic [WIDTH+1:0] w_pick_a, w_pick_b;
  logic             w_a_port, w_a_pres, w_b_port, w_b_pres;
  logic [WIDTH-1:0] w_a_data, w_b_data, w_a, w_b, w_alu;
  logic             w_is_op, w_is_acc, w_b_used, w_fire, w_fu_valid;

  assign w_pick_a = f_pick(w_sel_a, in_data, in_valid, r_result, w_const);
  assign w_pick_b = f_pick(w_sel_b, in_data, in_valid, r_result, w_const);
  assign {w_a_port, w_a_pres, w_a_data} = w_pick_a;
  assign {w_b_port, w_b_pres, w_b_data} = w_pick_b;

  // A latched operand is the older one, so it is consumed first.
  assign w_a = r_val_a ? r_lat_a : w_a_data;
  assign w_b = r_val_b ? r_lat_b : w_b_data;

  assign w_is_op    = (w_op != OP_NOP) && (w_op <= OP_ACC);
  assign w_is_acc   = (w_op == OP_ACC);
  assign w_b_used   = !w_is_acc;
  assign w_fire     = !config_en && w_is_op && (r_val_a || w_a_pres) &&
                      (w_is_acc || r_val_b || w_b_pres);
  assign w_fu_valid = w_fire && (!w_is_acc || (r_cnt == w_len_m1));

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_MUL:  w_alu = w_a * w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_SHL:  w_alu = w_a << w_b[SH_W-1:0];
      OP_SHR:  w_alu = w_a >> w_b[SH_W-1:0];
      OP_PASS: w_alu = w_a;
      OP_ACC:  w_alu = r_acc + w_a;
      default: w_alu = '0;
    endcase
  end

  // Only input-port sources are latched; feedback and const are always present.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_val_a  <= 1'b0;
      r_val_b  <= 1'b0;
      r_lat_a  <= '0;
      r_lat_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (config_en) begin
      r_val_a <= 1'b0;
      r_val_b <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_a_port && w_a_pres && !(w_fire && !r_val_a)) begin
        r_val_a <= 1'b1;
        r_lat_a <= w_a_data;
      end else if (w_fire) begin
        r_val_a <= 1'b0;
      end

      if (w_b_used && w_b_port && w_b_pres && !(w_fire && !r_val_b)) begin
        r_val_b <= 1'b1;
        r_lat_b <= w_b_data;
      end else if (w_fire && w_b_used) begin
        r_val_b <= 1'b0;
      end

      if (!w_fire && ((w_a_port && w_a_pres && r_val_a) ||
                      (w_b_used && w_b_port && w_b_pres && r_val_b))) begin
        r_err <= 1'b1;
      end

      if (w_fire && w_is_acc) begin
        if (r_cnt == w_len_m1) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= r_acc + w_a;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (w_fu_valid) r_result <= w_alu;
    end
  end

  logic [N_OUT-1:0]       w_src_valid;
  logic [N_OUT*WIDTH-1:0] w_src_data;

  always_comb begin : out_mux
    logic [OSEL_W-1:0] osel;
    w_src_valid = '0;
    w_src_data  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      osel = w_cfg[OFF_OSEL + j*OSEL_W +: OSEL_W];
      if (osel == '0) begin
        w_src_valid[j]                = w_fu_valid;
        w_src_data[j*WIDTH +: WIDTH] = w_alu;
      end
      for (int k = 0; k < N_IN; k++) begin
        if (osel == OSEL_W'(k + 1)) begin
          w_src_valid[j]                = in_valid[k];
          w_src_data[j*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  logic [N_OUT*WIDTH-1:0] r_out_data;
  logic [N_OUT-1:0]       r_out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
    end else if (config_en) begin
      r_out_valid <= '0;
    end else begin
      r_out_valid <= w_src_valid;
      for (int j = 0; j < N_OUT; j++) begin
        if (w_src_valid[j]) r_out_data[j*WIDTH +: WIDTH] <= w_src_data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_block_pe_param.sv
// Self-checking bench for block_pe_param (WIDTH=8, N_IN=2, N_OUT=1): directed
// scenarios plus randomized traffic against a queue-based behavioural model.
module tb_block_pe_param;

  localparam int W    = 8;
  localparam int CFGW = 26;

  logic        clk = 1'b0;
  logic        reset, config_en, config_in, config_out;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [7:0]  out_data;
  logic [0:0]  out_valid;
  logic        err_overrun;

  int n_checks = 0;
  int n_errors = 0;

  block_pe_param #(.WIDTH(W), .N_IN(2), .N_OUT(1), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending operands as queues, fires counted up to acc_len.
  logic [CFGW-1:0] m_cfg;
  int m_pend_a[$];
  int m_pend_b[$];
  int m_acc, m_fires, m_result, m_out_data;
  bit m_out_valid, m_err;

  task automatic src(input int sel, output bit port, output bit v, output int d);
    port = 0; v = 0; d = 0;
    case (sel)
      0: begin port = 1; v = in_valid[0]; d = int'(in_data[7:0]);  end
      1: begin port = 1; v = in_valid[1]; d = int'(in_data[15:8]); end
      2: begin v = 1; d = m_result; end
      3: begin v = 1; d = int'(m_cfg[15:8]); end
      default: ;
    endcase
  endtask

  task automatic model_step();
    int op, len, osel, da, db, a, b, r;
    bit pa, pb, va, vb, acc, fire, fu;
    if (reset) begin
      m_cfg = '0; m_pend_a.delete(); m_pend_b.delete();
      m_acc = 0; m_fires = 0; m_result = 0; m_out_data = 0; m_out_valid = 0; m_err = 0;
      return;
    end
    if (config_en) begin
      m_cfg = {config_in, m_cfg[CFGW-1:1]};
      m_pend_a.delete(); m_pend_b.delete();
      m_acc = 0; m_fires = 0; m_out_valid = 0;
      return;
    end
    op   = int'(m_cfg[7:4]);
    len  = int'(m_cfg[23:16]);
    osel = int'(m_cfg[25:24]);
    src(int'(m_cfg[1:0]), pa, va, da);
    src(int'(m_cfg[3:2]), pb, vb, db);
    acc  = (op == 10);
    fire = (op >= 1 && op <= 10) && (m_pend_a.size() > 0 || va) &&
           (acc || m_pend_b.size() > 0 || vb);
    a = (m_pend_a.size() > 0) ? m_pend_a[0] : da;
    b = (m_pend_b.size() > 0) ? m_pend_b[0] : db;

    if (pa && va) begin
      if (!fire && m_pend_a.size() > 0) m_err = 1;
      if (!fire || m_pend_a.size() > 0) begin m_pend_a.delete(); m_pend_a.push_back(da); end
    end else if (fire) m_pend_a.delete();
    if (!acc) begin
      if (pb && vb) begin
        if (!fire && m_pend_b.size() > 0) m_err = 1;
        if (!fire || m_pend_b.size() > 0) begin m_pend_b.delete(); m_pend_b.push_back(db); end
      end else if (fire) m_pend_b.delete();
    end

    fu = 0; r = 0;
    if (fire) begin
      case (op)
        1: r = a + b;
        2: r = a - b;
        3: r = a * b;
        4: r = a & b;
        5: r = a | b;
        6: r = a ^ b;
        7: r = a << (b % 8);
        8: r = a >> (b % 8);
        9: r = a;
        default: r = 0;
      endcase
      if (acc) begin
        m_acc += a;
        m_fires++;
        if (m_fires >= ((len == 0) ? 1 : len)) begin
          fu = 1; r = m_acc; m_acc = 0; m_fires = 0;
        end
      end else fu = 1;
      r &= 255;
      if (fu) m_result = r;
    end

    if (osel == 0) begin
      m_out_valid = fu;
      if (fu) m_out_data = r;
    end else if (osel <= 2) begin
      m_out_valid = in_valid[osel-1];
      if (m_out_valid) m_out_data = (osel == 1) ? int'(in_data[7:0]) : int'(in_data[15:8]);
    end else m_out_valid = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out_data",    32'(out_data),    32'(m_out_data));
    check("out_valid",   32'(out_valid),   32'(m_out_valid));
    check("err_overrun", 32'(err_overrun), 32'(m_err));
    check("config_out",  32'(config_out),  32'(m_cfg[0]));
  endtask

  function automatic logic [CFGW-1:0] make_cfg(input int sa, input int sb, input int op,
                                               input int cst, input int len, input int osel);
    return {2'(osel), 8'(len), 8'(cst), 4'(op), 2'(sb), 2'(sa)};
  endfunction

  task automatic drive(input bit v0, input int d0, input bit v1, input int d1);
    in_valid = {v1, v0};
    in_data  = {8'(d1), 8'(d0)};
  endtask

  // Shifts v in LSB first; seen collects what config_out replayed meanwhile.
  task automatic load_cfg(input logic [CFGW-1:0] v, output logic [CFGW-1:0] seen);
    drive(0, 0, 0, 0);
    config_en = 1;
    seen[0] = config_out;
    for (int i = 0; i < CFGW; i++) begin
      config_in = v[i];
      tick();
      if (i < CFGW - 1) seen[i+1] = config_out;
    end
    config_en = 0;
    config_in = 0;
    check("cfg_bus", 32'(dut.w_cfg), 32'(v));
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  logic [CFGW-1:0] seen, pat;

  initial begin
    reset = 1; config_en = 0; config_in = 0;
    drive(0, 0, 0, 0);
    tick();
    check("reset_out_data",  32'(out_data),    32'h0);
    check("reset_out_valid", 32'(out_valid),   32'h0);
    check("reset_err",       32'(err_overrun), 32'h0);
    check("reset_cfg",       32'(dut.w_cfg),   32'h0);
    reset = 0;

    // Config shift and field decode, then replay of the pattern on config_out.
    pat = 26'h2A5C3F1;
    load_cfg(pat, seen);
    check("dec_opcode",  32'(dut.w_op),      32'(pat[7:4]));
    check("dec_const",   32'(dut.w_const),   32'(pat[15:8]));
    check("dec_acc_len", 32'(dut.w_acc_len), 32'(pat[23:16]));
    load_cfg(make_cfg(0, 1, 1, 0, 0, 0), seen);
    check("cfg_replay", 32'(seen), 32'(pat));

    // ADD with both operands in the same cycle.
    drive(1, 5, 1, 7); tick();
    check("add_data",  32'(out_data),  32'd12);
    check("add_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 0, 0); tick();
    check("add_pulse_once", 32'(out_valid), 32'd0);

    // SUB with skewed operands, 3-4 wraps to 0xFF.
    load_cfg(make_cfg(0, 1, 2, 0, 0, 0), seen);
    drive(1, 3, 0, 0); tick();
    check("sub_wait", 32'(out_valid), 32'd0);
    drive(0, 0, 0, 0); tick(); tick();
    drive(0, 0, 1, 4); tick();
    check("sub_data",  32'(out_data),  32'hFF);
    check("sub_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 0, 0); tick();
    check("sub_pulse_once", 32'(out_valid), 32'd0);

    // Overrun on operand a; ADD then uses the newer value.
    load_cfg(make_cfg(0, 1, 1, 0, 0, 0), seen);
    drive(1, 10, 0, 0); tick();
    check("ovr_before", 32'(err_overrun), 32'd0);
    drive(1, 20, 0, 0); tick();
    check("ovr_flag", 32'(err_overrun), 32'd1);
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 1, 1); tick();
    check("ovr_add_data", 32'(out_data),    32'd21);
    check("ovr_sticky",   32'(err_overrun), 32'd1);
    do_reset();
    check("ovr_cleared", 32'(err_overrun), 32'd0);

    // Accumulate four values, twice.
    load_cfg(make_cfg(0, 0, 10, 0, 4, 0), seen);
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 0, 0); tick();
      check("acc_valid", 32'(out_valid), 32'((i % 4) == 0));
      if (i == 4) check("acc_sum1", 32'(out_data), 32'd10);
      if (i == 8) check("acc_sum2", 32'(out_data), 32'd26);
    end

    // Reset in the middle of an accumulation.
    drive(1, 9, 0, 0); tick();
    drive(1, 9, 0, 0); tick();
    reset = 1; drive(1, 9, 1, 9); tick();
    check("mid_rst_data",  32'(out_data),  32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_cfg",   32'(dut.w_cfg), 32'h0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 1, i); tick();
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Passthrough of in1 on the output port; FU result is not routed there.
    load_cfg(make_cfg(0, 1, 1, 0, 0, 2), seen);
    drive(0, 0, 1, 8'hA5); tick();
    check("pass_data",  32'(out_data),  32'hA5);
    check("pass_valid", 32'(out_valid), 32'd1);
    drive(1, 1, 1, 2); tick();
    check("pass_not_fu", 32'(out_data), 32'd2);
    drive(0, 0, 0, 0); tick();
    check("pass_idle", 32'(out_valid), 32'd0);

    // Randomized configurations and traffic.
    for (int c = 0; c < 14; c++) begin
      do_reset();
      load_cfg(make_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                        $urandom_range(0, 255), $urandom_range(0, 5), $urandom_range(0, 3)), seen);
      for (int i = 0; i < 60; i++) begin
        drive($urandom_range(0, 1), $urandom_range(0, 255),
              $urandom_range(0, 1), $urandom_range(0, 255));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
